qracc_csr_regfile: RTL



---
 rtl/qracc_csr_regfile.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/qracc_csr_regfile.sv
// QRAcc CSR slave: bus-facing register file holding the layer config and driving
// controller strobes. Define QRACC_CSR_SHADOW_EN for shadow/active config copies.
package qracc_pkg;
  typedef struct packed {
    logic [31:0] data_in;
    logic [31:0] addr;
    logic        wen;
    logic        valid;
  } bus_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] data_out;
    logic        rd_data_valid;
  } bus_resp_t;

  typedef enum logic [2:0] {
    TRIGGER_IDLE            = 3'd0,
    TRIGGER_WRITE_IFMAP     = 3'd1,
    TRIGGER_WRITE_WEIGHTS   = 3'd2,
    TRIGGER_COMPUTE_ANALOG  = 3'd3,
    TRIGGER_COMPUTE_DIGITAL = 3'd4,
    TRIGGER_READ_OFMAP      = 3'd5,
    TRIGGER_RSVD6           = 3'd6,
    TRIGGER_RSVD7           = 3'd7
  } qracc_trigger_t;

  typedef struct packed {
    logic        binary_cfg;
    logic        unsigned_acts;
    logic [3:0]  adc_ref_range_shifts;
    logic [3:0]  filter_size_y;
    logic [3:0]  filter_size_x;
    logic [3:0]  stride_x;
    logic [3:0]  stride_y;
    logic [3:0]  n_input_bits_cfg;
    logic [3:0]  n_output_bits_cfg;
    logic [15:0] input_fmap_dimx;
    logic [15:0] input_fmap_dimy;
    logic [15:0] output_fmap_dimx;
    logic [15:0] output_fmap_dimy;
    logic [15:0] num_input_channels;
    logic [15:0] num_output_channels;
    logic [15:0] mapped_matrix_offset_x;
    logic [15:0] mapped_matrix_offset_y;
    logic [3:0]  padding;
    logic [7:0]  padding_value;
  } qracc_layer_t;

  typedef struct packed {
    logic         preserve_ifmap;
    qracc_layer_t layer;
  } qracc_config_t;

  function automatic qracc_layer_t layer_reset();
    qracc_layer_t c;
    c = '0;
    c.filter_size_x     = 4'd1;
    c.filter_size_y     = 4'd1;
    c.stride_x          = 4'd1;
    c.stride_y          = 4'd1;
    c.n_input_bits_cfg  = 4'd8;
    c.n_output_bits_cfg = 4'd8;
    return c;
  endfunction
endpackage

module qracc_csr_regfile
  import qracc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_CSR   = 7
) (
  input  logic           clk,
  input  logic           nrst,
  input  bus_req_t       bus_req_i,
  output bus_resp_t      bus_resp_o,
  input  logic           ctrl_busy_i,
  input  logic [3:0]     ctrl_state_i,
  output qracc_config_t  cfg_o,
  output qracc_trigger_t trigger_o,
  output logic           trigger_valid_o,
  output logic           clear_o,
  output logic           inst_write_mode_o
);
  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t         state_q;
  logic [31:0]    rdata_q;
  qracc_layer_t   layer_q;
  logic           err_q, iwm_q, pif_q, trig_vld_q, clr_q;
  qracc_trigger_t trig_q;

  function automatic qracc_layer_t layer_write(qracc_layer_t c, logic [2:0] i, logic [31:0] d);
    case (i)
      3'd1: begin
        c.binary_cfg = d[0];            c.unsigned_acts = d[1];
        c.adc_ref_range_shifts = d[7:4]; c.filter_size_y = d[11:8];
        c.filter_size_x = d[15:12];      c.stride_x = d[19:16];
        c.stride_y = d[23:20];           c.n_input_bits_cfg = d[27:24];
        c.n_output_bits_cfg = d[31:28];
      end
      3'd2: begin c.input_fmap_dimx = d[15:0];        c.input_fmap_dimy = d[31:16];        end
      3'd3: begin c.output_fmap_dimx = d[15:0];       c.output_fmap_dimy = d[31:16];       end
      3'd4: begin c.num_input_channels = d[15:0];     c.num_output_channels = d[31:16];    end
      3'd5: begin c.mapped_matrix_offset_x = d[15:0]; c.mapped_matrix_offset_y = d[31:16]; end
      3'd6: begin c.padding = d[3:0];                 c.padding_value = d[11:4];           end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] layer_read(qracc_layer_t c, logic [2:0] i);
    logic [31:0] r;
    r = '0;
    case (i)
      3'd1: r = {c.n_output_bits_cfg, c.n_input_bits_cfg, c.stride_y, c.stride_x,
                 c.filter_size_x, c.filter_size_y, c.adc_ref_range_shifts, 2'b00,
                 c.unsigned_acts, c.binary_cfg};
      3'd2: r = {c.input_fmap_dimy, c.input_fmap_dimx};
      3'd3: r = {c.output_fmap_dimy, c.output_fmap_dimx};
      3'd4: r = {c.num_output_channels, c.num_input_channels};
      3'd5: r = {c.mapped_matrix_offset_y, c.mapped_matrix_offset_x};
      3'd6: r = {20'd0, c.padding_value, c.padding};
      default: r = '0;
    endcase
    return r;
  endfunction

  // 33-bit subtract: the borrow bit flags addresses below BASE_ADDR
  logic [32:0] off;
  logic        in_range, unused_addr_lsbs;
  logic [2:0]  idx;
  assign off              = {1'b0, bus_req_i.addr} - {1'b0, BASE_ADDR};
  assign in_range         = !off[32] && (off[31:2] < 30'(NUM_CSR));
  assign idx              = off[4:2];
  assign unused_addr_lsbs = ^off[1:0];

  logic accept, wr, rd, csr0_wr, cfg_wr, trig_req, trig_go, cfg_wr_ok, err_set;
  logic [31:0] csr0_word, rd_word;
  assign accept   = bus_req_i.valid && (state_q == S_IDLE);
  assign wr       = accept && bus_req_i.wen && in_range;
  assign rd       = accept && !bus_req_i.wen;
  assign csr0_wr  = wr && (idx == 3'd0);
  assign cfg_wr   = wr && (idx != 3'd0);
  assign trig_req = csr0_wr && (bus_req_i.data_in[2:0] != 3'd0);
  assign trig_go  = trig_req && !ctrl_busy_i;
`ifdef QRACC_CSR_SHADOW_EN
  assign cfg_wr_ok = cfg_wr;
  assign err_set   = trig_req && ctrl_busy_i;
`else
  assign cfg_wr_ok = cfg_wr && !ctrl_busy_i;
  assign err_set   = (trig_req || cfg_wr) && ctrl_busy_i;
`endif

  assign csr0_word = {18'd0, err_q, pif_q, ctrl_state_i, 2'b00, iwm_q, ctrl_busy_i, 4'd0};
  assign rd_word   = !in_range ? 32'd0 : (idx == 3'd0) ? csr0_word : layer_read(layer_q, idx);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (rd) begin state_q <= S_RESP; rdata_q <= rd_word; end
        S_RESP: begin state_q <= S_IDLE; rdata_q <= '0; end
        default: begin state_q <= S_IDLE; rdata_q <= '0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      layer_q    <= layer_reset();
      err_q      <= 1'b0;
      iwm_q      <= 1'b0;
      pif_q      <= 1'b0;
      trig_vld_q <= 1'b0;
      trig_q     <= TRIGGER_IDLE;
      clr_q      <= 1'b0;
    end else begin
      trig_vld_q <= trig_go;
      trig_q     <= trig_go ? qracc_trigger_t'(bus_req_i.data_in[2:0]) : TRIGGER_IDLE;
      clr_q      <= csr0_wr && bus_req_i.data_in[3];
      if (csr0_wr) begin
        iwm_q <= bus_req_i.data_in[5];
        pif_q <= bus_req_i.data_in[12];
      end
      // a new error outranks a same-write W1C or clear
      if (err_set)
        err_q <= 1'b1;
      else if (csr0_wr && (bus_req_i.data_in[13] || bus_req_i.data_in[3]))
        err_q <= 1'b0;
      if (cfg_wr_ok) layer_q <= layer_write(layer_q, idx, bus_req_i.data_in);
    end
  end

`ifdef QRACC_CSR_SHADOW_EN
  qracc_layer_t act_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        act_q <= layer_reset();
    else if (trig_go) act_q <= layer_q;
  end
  assign cfg_o.layer = act_q;
`else
  assign cfg_o.layer = layer_q;
`endif

  assign cfg_o.preserve_ifmap        = pif_q;
  assign bus_resp_o.ready            = (state_q == S_IDLE);
  assign bus_resp_o.rd_data_valid    = (state_q == S_RESP);
  assign bus_resp_o.data_out         = rdata_q;
  assign trigger_o                   = trig_q;
  assign trigger_valid_o             = trig_vld_q;
  assign clear_o                     = clr_q;
  assign inst_write_mode_o           = iwm_q;
endmodule
